// File: rtl/register_file_sequencer_if.sv
// Command/response bus between the control path and the register file sequencer.
// The control path uses the master side. The sequencer uses the slave side.
interface register_file_sequencer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [2:0]            cmd_op;
  logic [ADDR_WIDTH-1:0] cmd_src;
  logic [ADDR_WIDTH-1:0] cmd_dst;
  logic [DATA_WIDTH-1:0] cmd_data;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_error;

  modport master (
    output cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_error
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_error
  );
endinterface

// File: rtl/register_file_sequencer.sv
// Command-driven master for the GPR register file.
// It accepts one operation per handshake and sequences the bank's read and write ports.
// It returns one response per command. It is the only writer of the bank.
// Every bank-facing output comes from a flop, so write_enable cannot glitch.
module register_file_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  register_file_sequencer_if.slave bus,
  output logic [ADDR_WIDTH-1:0]  rf_read_address,
  input  logic [DATA_WIDTH-1:0]  rf_read_data,
  output logic [ADDR_WIDTH-1:0]  rf_write_address,
  output logic [DATA_WIDTH-1:0]  rf_write_data,
  output logic                   rf_write_enable
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_REG = ADDR_WIDTH'(NUM_REGS - 1);

  localparam logic [2:0] OP_WRITE = 3'd0;
  localparam logic [2:0] OP_READ  = 3'd1;
  localparam logic [2:0] OP_COPY  = 3'd2;
  localparam logic [2:0] OP_SWAP  = 3'd3;
  localparam logic [2:0] OP_ADDI  = 3'd4;
  localparam logic [2:0] OP_CLEAR = 3'd5;

  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    RD_B,
    WR_A,
    WR_B,
    CLR,
    RESP
  } state_t;

  state_t                state_q;
  logic [2:0]            op_q;
  logic [ADDR_WIDTH-1:0] src_q;
  logic [ADDR_WIDTH-1:0] dst_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] tmpA_q;
  logic [DATA_WIDTH-1:0] tmpB_q;
  logic [ADDR_WIDTH-1:0] clrCnt_q;
  logic [ADDR_WIDTH-1:0] rdAddr_q;
  logic [ADDR_WIDTH-1:0] wrAddr_q;
  logic [DATA_WIDTH-1:0] wrData_q;
  logic                  wrEn_q;
  logic                  rspValid_q;
  logic [DATA_WIDTH-1:0] rspData_q;
  logic                  rspError_q;

  assign bus.cmd_ready  = (state_q == IDLE);
  assign bus.rsp_valid  = rspValid_q;
  assign bus.rsp_data   = rspData_q;
  assign bus.rsp_error  = rspError_q;
  assign rf_read_address  = rdAddr_q;
  assign rf_write_address = wrAddr_q;
  assign rf_write_data    = wrData_q;
  assign rf_write_enable  = wrEn_q;

  // Sequencer FSM. Every output is set on the edge that enters the state that uses it.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      op_q       <= '0;
      src_q      <= '0;
      dst_q      <= '0;
      data_q     <= '0;
      tmpA_q     <= '0;
      tmpB_q     <= '0;
      clrCnt_q   <= '0;
      rdAddr_q   <= '0;
      wrAddr_q   <= '0;
      wrData_q   <= '0;
      wrEn_q     <= 1'b0;
      rspValid_q <= 1'b0;
      rspData_q  <= '0;
      rspError_q <= 1'b0;
    end else begin
      wrEn_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.cmd_valid) begin
            op_q       <= bus.cmd_op;
            src_q      <= bus.cmd_src;
            dst_q      <= bus.cmd_dst;
            data_q     <= bus.cmd_data;
            rspError_q <= 1'b0;
            case (bus.cmd_op)
              OP_WRITE: begin
                wrAddr_q <= bus.cmd_dst;
                wrData_q <= bus.cmd_data;
                wrEn_q   <= 1'b1;
                state_q  <= WR_A;
              end
              OP_READ, OP_COPY, OP_SWAP, OP_ADDI: begin
                rdAddr_q <= bus.cmd_src;
                state_q  <= RD_A;
              end
              OP_CLEAR: begin
                clrCnt_q <= '0;
                wrAddr_q <= '0;
                wrData_q <= '0;
                wrEn_q   <= 1'b1;
                state_q  <= CLR;
              end
              default: begin
                rspData_q  <= '0;
                rspError_q <= 1'b1;
                rspValid_q <= 1'b1;
                state_q    <= RESP;
              end
            endcase
          end
        end
        RD_A: begin
          tmpA_q <= rf_read_data;
          case (op_q)
            OP_READ: begin
              rspData_q  <= rf_read_data;
              rspValid_q <= 1'b1;
              state_q    <= RESP;
            end
            OP_SWAP: begin
              rdAddr_q <= dst_q;
              state_q  <= RD_B;
            end
            OP_ADDI: begin
              wrAddr_q <= dst_q;
              wrData_q <= rf_read_data + data_q;
              wrEn_q   <= 1'b1;
              state_q  <= WR_A;
            end
            default: begin
              wrAddr_q <= dst_q;
              wrData_q <= rf_read_data;
              wrEn_q   <= 1'b1;
              state_q  <= WR_A;
            end
          endcase
        end
        RD_B: begin
          tmpB_q   <= rf_read_data;
          wrAddr_q <= dst_q;
          wrData_q <= tmpA_q;
          wrEn_q   <= 1'b1;
          state_q  <= WR_A;
        end
        WR_A: begin
          if (op_q == OP_SWAP) begin
            wrAddr_q <= src_q;
            wrData_q <= tmpB_q;
            wrEn_q   <= 1'b1;
            state_q  <= WR_B;
          end else begin
            // For WRITE, COPY and ADDI, the value just written is the response value.
            rspData_q  <= wrData_q;
            rspValid_q <= 1'b1;
            state_q    <= RESP;
          end
        end
        WR_B: begin
          rspData_q  <= tmpA_q;
          rspValid_q <= 1'b1;
          state_q    <= RESP;
        end
        CLR: begin
          if (clrCnt_q == LAST_REG) begin
            clrCnt_q   <= '0;
            rspData_q  <= '0;
            rspValid_q <= 1'b1;
            state_q    <= RESP;
          end else begin
            clrCnt_q <= clrCnt_q + 1'b1;
            wrAddr_q <= clrCnt_q + 1'b1;
            wrData_q <= '0;
            wrEn_q   <= 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rspValid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
